// File: rtl/dff_share_arbiter_pkg.sv
// Shared definitions for the round-robin D flip-flop capture arbiter:
// FSM state encodings and a constant-friendly ceil(log2) helper.
package dff_share_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // ceil(log2(v)); returns 0 for v <= 1, usable in parameter expressions
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_share_arbiter_rr_pick.sv
// Cyclic first-set search: finds the first asserted request at or after ptr,
// wrapping from N_REQ-1 back to 0. Purely combinational.
module dff_share_arbiter_rr_pick
    import dff_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // One extra bit addresses the doubled request vector, so ptr+offset
    // never needs a modulo.
    localparam int SW = IDX_W + 1;

    logic [2*N_REQ-1:0] req2;
    logic [SW-1:0]      pos;
    logic [SW-1:0]      wrapped;
    logic               found;

    assign req2 = {req, req};

    // Scan offsets 0..N_REQ-1 from ptr; the first hit wins
    always_comb begin
        any     = |req;
        idx     = '0;
        found   = 1'b0;
        pos     = '0;
        wrapped = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = SW'(ptr) + SW'(i);
            if (!found && req2[pos]) begin
                found   = 1'b1;
                wrapped = (pos >= SW'(N_REQ)) ? (pos - SW'(N_REQ)) : pos;
                idx     = wrapped[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// Shares one WIDTH-bit q/q_bar capture bank among N_REQ requesters.
// IDLE arbitrates round-robin, GRANT lasts one cycle while the owner drives d,
// HOLD keeps the capture valid until ack or until HOLD_MAX cycles expire.
module dff_share_arbiter
    import dff_share_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 15,
    parameter int IDX_W    = clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] d,
    input  logic                   ack,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       q_bar,
    output logic                   q_valid,
    output logic [IDX_W-1:0]       q_owner,
    output logic                   timeout
);

    // Wide enough to hold HOLD_MAX-1 and never zero-width
    localparam int CNT_W = (clog2(HOLD_MAX + 1) < 1) ? 1 : clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    logic [1:0]       state_q,   state_d;
    logic [N_REQ-1:0] gnt_q,     gnt_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic [WIDTH-1:0] data_bar_q, data_bar_d;
    logic             valid_q,   valid_d;
    logic [IDX_W-1:0] owner_q,   owner_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] ptr_q,     ptr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [WIDTH-1:0] d_arr [N_REQ];
    logic [WIDTH-1:0] d_sel;

    // Unpack the flat data bus into one lane per requester
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        assign d_arr[gi] = d[gi*WIDTH +: WIDTH];
    end

    assign d_sel = d_arr[owner_q];

    dff_share_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Next-state logic: arbitration only in IDLE, capture on GRANT->HOLD
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        data_d     = data_q;
        data_bar_d = data_bar_q;
        valid_d    = valid_q;
        owner_d    = owner_q;
        timeout_d  = 1'b0;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d   = N_REQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Captured even if the owner dropped req during GRANT
                data_d     = d_sel;
                data_bar_d = ~d_sel;
                valid_d    = 1'b1;
                gnt_d      = '0;
                cnt_d      = '0;
                ptr_d      = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                // ack takes priority over expiry on the same edge
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            data_q     <= '0;
            data_bar_q <= '1;
            valid_q    <= 1'b0;
            owner_q    <= '0;
            timeout_q  <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            data_q     <= data_d;
            data_bar_q <= data_bar_d;
            valid_q    <= valid_d;
            owner_q    <= owner_d;
            timeout_q  <= timeout_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign q       = data_q;
    assign q_bar   = data_bar_q;
    assign q_valid = valid_q;
    assign q_owner = owner_q;
    assign timeout = timeout_q;

endmodule
